// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the instruction-fetch slice.
// Holds the machine width, the reset PC, the canonical NOP encoding, the
// fetch-queue payload and the fetch FSM state encoding.
package riscv_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] RST_PC    = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One decoded-side queue entry: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } fetch_state_e;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO used twice by fetch_unit, once for
// returned instruction entries and once for the addresses of granted requests.
// Depth must be a power of two; flush empties it in one cycle and a push and a
// pop may happen together at any occupancy, including when full.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  T                        wdata_i,
    output T                        rdata_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);

    // Pointer and occupancy bookkeeping; flush discards everything regardless of push/pop.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; stale slots are never read while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the fetch PC, issues word requests
// to instruction memory under a credit scheme (requests in flight plus queued
// entries never exceed FIFO_DEPTH), tags returning words with their address and
// hands {instr, pc, pc+4} to decode over valid/ready. A redirect from EX flushes
// the queue, marks every in-flight request for discard and restarts at target.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_redirects / perf_starve.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              FIFO_DEPTH   = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = RST_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsrc,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_starve
`endif
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   occupancy, occupancy_next, tag_count;
    logic [CW:0]     used_now, used_next;
    fetch_entry_t    head_entry, push_entry;
    logic [XLEN-1:0] tag_pc;
    logic            pop, gnt_fire, rv_fire, rv_keep;
    logic            credit_ok, all_in_flight, data_empty;

    // Handshake qualifiers. The entry handed to decode this cycle returns its credit
    // immediately, which is what lets fetch sustain one instruction per cycle.
    assign pop       = if_valid && if_ready;
    assign used_now  = {1'b0, outstanding_q} + {1'b0, occupancy};
    assign credit_ok = used_now < (DEPTH_W + (CW+1)'(pop));
    assign imem_req  = (state_q == FETCH) && credit_ok;
    assign gnt_fire  = imem_req && imem_gnt;
    assign rv_fire   = imem_rvalid && (outstanding_q != '0);
    assign rv_keep   = rv_fire && (discard_q == '0) && !pcsrc;

    // Credit accounting after this cycle's grant/response/pop/redirect.
    assign outstanding_d  = outstanding_q + CW'(gnt_fire) - CW'(rv_fire);
    assign occupancy_next = pcsrc ? '0 : (occupancy + CW'(rv_keep) - CW'(pop));
    assign used_next      = {1'b0, outstanding_d} + {1'b0, occupancy_next};
    assign all_in_flight  = (used_next == DEPTH_W) && (occupancy_next == '0);

    // Next-state logic: FULL means every credit sits in memory, so nothing in this
    // stage can free one until a response comes back; a redirect always resumes FETCH.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = all_in_flight ? FULL : FETCH;
            FULL:    state_d = all_in_flight ? FULL : FETCH;
            default: state_d = BOOT;
        endcase
        if (pcsrc && (state_q != BOOT)) begin
            state_d = FETCH;
        end
    end

    // Fetch PC and discard bookkeeping. On redirect every request still in flight,
    // including one granted this very cycle, must have its response thrown away.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (pcsrc) begin
            fetch_pc_d = word_align(pc_target);
            discard_d  = outstanding_d;
        end else begin
            if (gnt_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rv_fire && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_VECTOR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Addresses of granted, non-discarded requests, oldest first; each kept response pops one.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_tag_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (pcsrc),
        .push_i  (gnt_fire),
        .pop_i   (rv_keep),
        .wdata_i (fetch_pc_q),
        .rdata_o (tag_pc),
        .count_o (tag_count)
    );

    assign push_entry = '{instr: imem_rdata, pc: tag_pc};

    // Instruction queue feeding decode; written one cycle before it becomes visible.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_data_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (pcsrc),
        .push_i  (rv_keep),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (occupancy)
    );

    assign data_empty  = (occupancy == '0);
    assign if_valid    = !data_empty;
    assign if_instr    = data_empty ? NOP_INSTR : head_entry.instr;
    assign if_pc       = data_empty ? '0 : head_entry.pc;
    assign if_pc_plus4 = if_pc + 32'd4;
    assign imem_addr   = fetch_pc_q;

    // Protocol and bookkeeping checks; they never influence the datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rvalid && (outstanding_q == '0)))
                else $error("fetch_unit: imem_rvalid with no outstanding request");
            assert (tag_count == (outstanding_q - discard_q))
                else $error("fetch_unit: tag queue out of step with outstanding count");
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirects_q, redirects_d;
    logic [31:0] starve_q, starve_d;

    // Saturating event counters: redirects seen and cycles decode waited on fetch.
    always_comb begin
        redirects_d = redirects_q;
        starve_d    = starve_q;
        if (pcsrc && (redirects_q != '1)) begin
            redirects_d = redirects_q + 32'd1;
        end
        if (if_ready && !if_valid && (starve_q != '1)) begin
            starve_d = starve_q + 32'd1;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirects_q <= '0;
            starve_q    <= '0;
        end else begin
            redirects_q <= redirects_d;
            starve_q    <= starve_d;
        end
    end

    assign perf_redirects = redirects_q;
    assign perf_starve    = starve_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A queue-based reference
// model tracks requests in flight (with a stale flag for redirected ones) and
// the entries decode should see; a memory responder answers grants in order
// with a random latency. Build with FETCH_PERF_CNT_EN to check the counters.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcsrc = 1'b0;
    logic [31:0] pc_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_starve;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .FIFO_DEPTH   (DEPTH),
        .RESET_VECTOR (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pcsrc       (pcsrc),
        .pc_target   (pc_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_redirects (perf_redirects),
        .perf_starve    (perf_starve)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          readyCyc;
    } flight_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    flight_t     inflight[$];
    entry_t      decQ[$];
    logic [31:0] mPc;
    int          cyc;
    int          nCompared = 0;
    int          nMismatched = 0;
    int          mRedirects;
    int          mStarve;
    int          grantCount;
    int          gntPct;
    int          rvPct;
    int          maxLat;

    // Memory contents: a scrambled function of the word address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Hold reset for one edge, check every output, then clear the model.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        pcsrc = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        if_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, RST_PC);
        checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("rst_if_instr", if_instr, 32'h0000_0013);
        checkOutput("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("rst_perf_redirects", perf_redirects, 32'd0);
        checkOutput("rst_perf_starve", perf_starve, 32'd0);
`endif
        inflight.delete();
        decQ.delete();
        mPc = RST_PC;
        cyc = 0;
        mRedirects = 0;
        mStarve = 0;
        grantCount = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic applyStimulus(input bit doRedirect, input logic [31:0] target, input bit readyV);
        bit gntV, rvV, popV, mReq, gFire;
        int lat;
        flight_t r;
        @(negedge clk);
        rst = 1'b0;
        pcsrc = doRedirect;
        pc_target = target;
        if_ready = readyV;
        gntV = ($urandom_range(0, 99) < gntPct);
        rvV = (inflight.size() > 0) && (inflight[0].readyCyc <= cyc) && ($urandom_range(0, 99) < rvPct);
        imem_gnt = gntV;
        imem_rvalid = rvV;
        imem_rdata = rvV ? memWord(inflight[0].addr) : $urandom;
        #1;
        popV = (decQ.size() > 0) && readyV;
        mReq = (cyc > 0) && ((inflight.size() + decQ.size() - (popV ? 1 : 0)) < DEPTH);
        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, mReq});
        checkOutput("imem_addr", imem_addr, mPc);
        checkOutput("if_valid", {31'b0, if_valid}, {31'b0, (decQ.size() > 0)});
        if (decQ.size() > 0) begin
            checkOutput("if_pc", if_pc, decQ[0].pc);
            checkOutput("if_instr", if_instr, decQ[0].instr);
            checkOutput("if_pc_plus4", if_pc_plus4, decQ[0].pc + 32'd4);
        end
        if (doRedirect) mRedirects++;
        if (readyV && (decQ.size() == 0)) mStarve++;
        gFire = imem_req && gntV;
        if (popV) void'(decQ.pop_front());
        if (rvV) begin
            r = inflight.pop_front();
            if (!r.stale && !doRedirect) decQ.push_back('{instr: memWord(r.addr), pc: r.addr});
        end
        if (gFire) begin
            lat = int'($urandom_range(0, maxLat - 1));
            inflight.push_back('{addr: mPc, stale: 1'b0, readyCyc: cyc + 1 + lat});
            mPc = mPc + 32'd4;
            grantCount++;
        end
        if (doRedirect) begin
            decQ.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            mPc = {target[31:2], 2'b00};
        end
        cyc++;
    endtask

`ifdef FETCH_PERF_CNT_EN
    // Idle cycle so the counters have absorbed every modelled event, then compare.
    task automatic checkPerf();
        @(negedge clk);
        rst = 1'b0;
        pcsrc = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        if_ready = 1'b0;
        #1;
        checkOutput("perf_redirects", perf_redirects, mRedirects);
        checkOutput("perf_starve", perf_starve, mStarve);
        cyc++;
    endtask
`endif

    initial begin
        gntPct = 100;
        rvPct = 100;
        maxLat = 1;

        $display("[TB] reset and streaming fetch");
        doReset();
        repeat (20) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] decode stall fills the credits");
        doReset();
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("stall_grants", grantCount, DEPTH);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] redirect with requests in flight");
        doReset();
        rvPct = 0;
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0100, 1'b1);
        rvPct = 100;
        repeat (12) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] redirect coinciding with grant and response");
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0240, 1'b1);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] address wrap and unaligned target");
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0102, 1'b1);
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] randomized traffic");
        gntPct = 70;
        rvPct = 60;
        maxLat = 4;
        for (int i = 0; i < 300; i++) begin
            applyStimulus((cyc > 0) && ($urandom_range(0, 99) < 5), $urandom, ($urandom_range(0, 3) != 0));
        end
`ifdef FETCH_PERF_CNT_EN
        checkPerf();
`endif

        $display("[TB] reset with two requests outstanding");
        doReset();
        gntPct = 100;
        rvPct = 0;
        maxLat = 1;
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);
        doReset();

        $display("[TB] three redirects");
        rvPct = 100;
        repeat (3) begin
            repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
            applyStimulus(1'b1, $urandom, 1'b1);
        end
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        checkPerf();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
